mac_hdr_lookup: RTL

- Upstream stage of the MAC address table (mac_mem).
- Consumes the merged ingress byte stream and captures the 48-bit DA and SA from each frame header.
- Folds each address to a pADDR_WIDTH table index, issues one learn/lookup transaction per frame, and returns the forwarding decision (egress port or flood) to the switch fabric.

---
 rtl/mac_hdr_lookup_if.sv | 38 +++
 rtl/mac_hdr_lookup.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mac_hdr_lookup_if.sv
// Ingress byte stream plus MAC-table request/response bundle for mac_hdr_lookup.
// slave = the lookup block, master = the upstream stream source and table.
interface mac_hdr_lookup_if #(
  parameter int pNUM_PORTS  = 4,
  parameter int pADDR_WIDTH = 14
);
  localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;

  logic [7:0]             idata;
  logic                   ivalid;
  logic                   isop;
  logic                   ieop;
  logic [PW-1:0]          iport;
  logic                   otready;
  logic [pADDR_WIDTH-1:0] oda_hash;
  logic [pADDR_WIDTH-1:0] osa_hash;
  logic [PW-1:0]          osrc_port;
  logic                   owr_en;
  logic [PW-1:0]          ilu_port;
  logic                   ilu_ready;
  logic                   ores_valid;
  logic [PW-1:0]          ores_port;
  logic                   ores_flood;
  logic                   ores_timeout;
  logic [15:0]            odrop_cnt;

  modport slave (
    input  idata, ivalid, isop, ieop, iport, ilu_port, ilu_ready,
    output otready, oda_hash, osa_hash, osrc_port, owr_en,
    output ores_valid, ores_port, ores_flood, ores_timeout, odrop_cnt
  );

  modport master (
    output idata, ivalid, isop, ieop, iport, ilu_port, ilu_ready,
    input  otready, oda_hash, osa_hash, osrc_port, owr_en,
    input  ores_valid, ores_port, ores_flood, ores_timeout, odrop_cnt
  );
endinterface

// File: rtl/mac_hdr_lookup.sv
// Captures DA/SA from each frame header, issues one learn/lookup to the MAC table, returns a forwarding decision.
// Latency: byte 11 at T -> owr_en at T+1 -> ores_valid >= T+3; otready drops during LOOKUP/RESP to stall the byte stream.
module mac_hdr_lookup #(
  parameter int pNUM_PORTS  = 4,
  parameter int pADDR_WIDTH = 14,
  parameter int pTIMEOUT    = 64
) (
  input  logic            iclk,
  input  logic            irst_n,
  mac_hdr_lookup_if.slave bus
);
  localparam int PW   = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;
  localparam int NSL  = (48 + pADDR_WIDTH - 1) / pADDR_WIDTH;
  localparam int EXTW = NSL * pADDR_WIDTH;
  localparam int TW   = $clog2(pTIMEOUT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_LOOKUP, ST_RESP, ST_DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [87:0]            hdr;
  logic [95:0]            hdr_nxt;
  logic [3:0]             idx;
  logic [PW-1:0]          src_port;
  logic                   da_mc;
  logic                   last_eop;
  logic [TW-1:0]          tcnt;
  logic [pADDR_WIDTH-1:0] da_hash_q, sa_hash_q;
  logic [PW-1:0]          src_q;
  logic                   wr_en_q;
  logic                   res_vld_q;
  logic [PW-1:0]          res_port_q;
  logic                   res_flood_q, res_to_q;
  logic [15:0]            drop_q;
  logic                   rdy, accept;
  logic                   cap_first, cap_byte, drop_inc, go_lookup, lu_hit, lu_to;

  // XOR of pADDR_WIDTH-bit slices; the top slice is zero-extended.
  function automatic logic [pADDR_WIDTH-1:0] fold(input logic [47:0] a);
    logic [EXTW-1:0]        ext;
    logic [pADDR_WIDTH-1:0] h;
    ext = EXTW'(a);
    h   = '0;
    for (int i = 0; i < NSL; i++) h ^= ext[i*pADDR_WIDTH +: pADDR_WIDTH];
    return h;
  endfunction

  assign rdy     = (state == ST_IDLE) || (state == ST_HDR) || (state == ST_DRAIN);
  assign accept  = bus.ivalid && rdy;
  assign hdr_nxt = {hdr, bus.idata};

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_first = 1'b0;
    cap_byte  = 1'b0;
    drop_inc  = 1'b0;
    go_lookup = 1'b0;
    lu_hit    = 1'b0;
    lu_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && bus.isop) begin
          cap_first = 1'b1;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (bus.isop) begin
            cap_first = 1'b1;
            drop_inc  = 1'b1;
          end else begin
            cap_byte = 1'b1;
            if (idx == 4'd11) begin
              go_lookup = 1'b1;
              state_nxt = ST_LOOKUP;
            end else if (bus.ieop) begin
              drop_inc  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_LOOKUP: begin
        // The first LOOKUP cycle carries the learn write, so ready is not trusted until the second.
        if (tcnt != '0 && bus.ilu_ready) begin
          lu_hit    = 1'b1;
          state_nxt = ST_RESP;
        end else if (tcnt == TW'(pTIMEOUT - 1)) begin
          lu_to     = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = last_eop ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (accept) begin
          if (bus.isop) begin
            cap_first = 1'b1;
            drop_inc  = 1'b1;
            state_nxt = ST_HDR;
          end else if (bus.ieop) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      hdr         <= '0;
      idx         <= '0;
      src_port    <= '0;
      da_mc       <= 1'b0;
      last_eop    <= 1'b0;
      tcnt        <= '0;
      da_hash_q   <= '0;
      sa_hash_q   <= '0;
      src_q       <= '0;
      wr_en_q     <= 1'b0;
      res_vld_q   <= 1'b0;
      res_port_q  <= '0;
      res_flood_q <= 1'b0;
      res_to_q    <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (cap_first) begin
        hdr      <= {80'b0, bus.idata};
        src_port <= bus.iport;
        idx      <= 4'd1;
      end else if (cap_byte) begin
        hdr <= hdr_nxt[87:0];
        idx <= idx + 4'd1;
      end

      wr_en_q <= 1'b0;
      if (go_lookup) begin
        da_hash_q <= fold(hdr_nxt[95:48]);
        sa_hash_q <= fold(hdr_nxt[47:0]);
        src_q     <= src_port;
        wr_en_q   <= ~hdr_nxt[40];
        da_mc     <= hdr_nxt[88];
        last_eop  <= bus.ieop;
        tcnt      <= '0;
      end else if (state == ST_LOOKUP) begin
        tcnt <= tcnt + 1'b1;
      end

      res_vld_q <= lu_hit | lu_to;
      if (lu_hit) begin
        res_port_q  <= bus.ilu_port;
        res_flood_q <= da_mc || (bus.ilu_port == src_q);
        res_to_q    <= 1'b0;
      end else if (lu_to) begin
        res_port_q  <= '0;
        res_flood_q <= 1'b1;
        res_to_q    <= 1'b1;
      end

      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.otready      = rdy;
  assign bus.oda_hash     = da_hash_q;
  assign bus.osa_hash     = sa_hash_q;
  assign bus.osrc_port    = src_q;
  assign bus.owr_en       = wr_en_q;
  assign bus.ores_valid   = res_vld_q;
  assign bus.ores_port    = res_port_q;
  assign bus.ores_flood   = res_flood_q;
  assign bus.ores_timeout = res_to_q;
  assign bus.odrop_cnt    = drop_q;
endmodule
